tof_result_collector: RTL and testbench

Downstream consumer of the 8-sensor I2C ToF communication block. It watches the per-sensor ready vector and round-robin arbitrates among sensors with pending results. It drives the 3-bit sensor select and captures the muxed {zone index, distance} word. Captured results are queued in a FIFO and presented to the host/packetiser as a valid/ready stream.

---
 rtl/tof_collect_pkg.sv | 34 +++
 rtl/tof_result_fifo.sv | 93 +++++++++
 rtl/tof_result_collector.sv | 165 ++++++++++++++++
 tb/tb_tof_result_collector.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tof_collect_pkg.sv
// Shared definitions for the ToF result collector: FSM state encoding,
// result-word field layout and the FIFO entry width.
// Optional feature macro: TOF_COLLECT_TIMESTAMP_EN (adds a 16-bit capture
// timestamp in the top bits of every FIFO entry).
package tof_collect_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // Field widths of one result entry.
    localparam int DIST_W = 16;
    localparam int ZONE_W = 6;
    localparam int ID_W   = 3;
    localparam int TS_W   = 16;

    // Field offsets inside an entry: {ts, id, zone, distance}.
    localparam int DIST_LSB = 0;
    localparam int ZONE_LSB = DIST_LSB + DIST_W;
    localparam int ID_LSB   = ZONE_LSB + ZONE_W;
    localparam int TS_LSB   = ID_LSB + ID_W;

    // Width of the muxed word coming from the comm block.
    localparam int DATA_W = ZONE_W + DIST_W;

`ifdef TOF_COLLECT_TIMESTAMP_EN
    localparam int ENTRY_W = TS_W + ID_W + DATA_W;
`else
    localparam int ENTRY_W = ID_W + DATA_W;
`endif

endpackage

// File: rtl/tof_result_fifo.sv
// First-word-fall-through FIFO with a registered head.
// The head register holds the oldest entry whenever the FIFO is non-empty;
// the storage array holds everything behind it. A push into an empty FIFO
// (or into one whose only entry is being popped) bypasses the array so the
// data is visible on the very next cycle.
module tof_result_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop_req,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] count_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             valid_reg;

    logic pop;
    logic push_ok;
    logic head_free;
    logic mem_has_data;
    logic load_from_mem;
    logic bypass;
    logic mem_wr;

    assign full  = (count_reg == LVL_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign level = count_reg;
    assign dout  = dout_reg;
    assign valid = valid_reg;

    // Transfer decisions: a pop frees a slot, so push into a full FIFO is
    // accepted when a pop happens in the same cycle.
    always_comb begin
        pop           = valid_reg && pop_req;
        push_ok       = push && (!full || pop);
        head_free     = !valid_reg || pop;
        mem_has_data  = (count_reg > LVL_W'(1));
        load_from_mem = head_free && mem_has_data;
        bypass        = head_free && !mem_has_data && push_ok;
        mem_wr        = push_ok && !bypass;
    end

    // Storage array write port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers, occupancy and the registered head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
            valid_reg  <= 1'b0;
        end else begin
            if (mem_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (load_from_mem) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                dout_reg   <= mem[rd_ptr_reg];
            end else if (bypass) begin
                dout_reg   <= din;
            end
            if (head_free) begin
                valid_reg <= load_from_mem || bypass;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + LVL_W'(1);
                2'b01:   count_reg <= count_reg - LVL_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/tof_result_collector.sv
// ToF result collector: round-robin arbitration over the per-sensor ready
// flags, sensor select towards the comm block, capture of the muxed result
// and queuing into a FWFT FIFO presented as a valid/ready stream.
// Optional feature macro: TOF_COLLECT_TIMESTAMP_EN (16-bit free-running
// counter stored in bits [40:25] of each entry).
module tof_result_collector
    import tof_collect_pkg::*;
#(
    parameter int NB_OF_SENSORS = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int SEL_W         = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NB_OF_SENSORS-1:0]      ready_in,
    input  logic [DATA_W-1:0]             data_in,
    output logic [SEL_W-1:0]              tof_index,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [ENTRY_W-1:0]            m_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    localparam int IDX_W = SEL_W + 1;

    state_t state_reg;
    state_t state_next;

    logic [SEL_W-1:0]         tof_index_reg;
    logic [SEL_W-1:0]         rr_ptr_reg;
    logic                     overflow_reg;

    logic [NB_OF_SENSORS-1:0] rotated;
    logic                     any_ready;
    logic [SEL_W-1:0]         grant_off;
    logic [SEL_W-1:0]         grant;
    logic                     index_load;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [ENTRY_W-1:0]       entry;

    // (base + off) modulo NB_OF_SENSORS; base is always a valid sensor
    // index, so a single conditional subtraction suffices.
    function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base,
                                                  input logic [SEL_W-1:0] off);
        logic [IDX_W-1:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= IDX_W'(NB_OF_SENSORS)) begin
            sum = sum - IDX_W'(NB_OF_SENSORS);
        end
        return sum[SEL_W-1:0];
    endfunction

    // Rotate the ready vector so that bit 0 is the sensor at rr_ptr; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    for (genvar gi = 0; gi < NB_OF_SENSORS; gi++) begin : g_rotate
        assign rotated[gi] = ready_in[wrap_idx(rr_ptr_reg, SEL_W'(gi))];
    end

    // Lowest-set-bit priority encoder over the rotated vector.
    always_comb begin
        any_ready = |rotated;
        grant_off = '0;
        for (int i = NB_OF_SENSORS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                grant_off = SEL_W'(i);
            end
        end
    end

    assign grant = wrap_idx(rr_ptr_reg, grant_off);

    // Next-state and control decode: grant in IDLE, settle in SELECT,
    // push in CAPTURE.
    always_comb begin
        state_next = state_reg;
        index_load = 1'b0;
        fifo_push  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_ready) begin
                    index_load = 1'b1;
                    state_next = SELECT;
                end
            end
            SELECT: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                fifo_push  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register, sensor select, round-robin pointer and sticky
    // overflow (a new drop wins over a clear in the same cycle).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            tof_index_reg <= '0;
            rr_ptr_reg    <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (index_load) begin
                tof_index_reg <= grant;
            end
            if (fifo_push) begin
                rr_ptr_reg <= wrap_idx(tof_index_reg, SEL_W'(1));
            end
            if (fifo_push && fifo_full && !fifo_pop) begin
                overflow_reg <= 1'b1;
            end else if (clr_overflow) begin
                overflow_reg <= 1'b0;
            end
        end
    end

`ifdef TOF_COLLECT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_reg;

    // Free-running capture timestamp; wraps naturally at 0xFFFF.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + TS_W'(1);
        end
    end

    assign entry = {ts_reg, ID_W'(tof_index_reg), data_in};
`else
    assign entry = {ID_W'(tof_index_reg), data_in};
`endif

    assign fifo_pop = m_ready && !fifo_empty;

    tof_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .din     (entry),
        .pop_req (m_ready),
        .dout    (m_data),
        .valid   (m_valid),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tof_index = tof_index_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_tof_result_collector.sv
// Directed testbench for tof_result_collector. The bench plays the comm
// block (per-sensor ready flags and a data table muxed by tof_index) and
// keeps a transaction-level model: a grant schedule on a cycle timeline
// plus a queue standing in for the FIFO. Every cycle the DUT outputs are
// compared against the model; hand-computed literals pin the model.
// Build with TOF_COLLECT_TIMESTAMP_EN to also exercise the timestamp.
module tb_tof_result_collector;
    import tof_collect_pkg::*;

    localparam int NB    = 8;
    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [NB-1:0]      ready_vec;
    logic [DATA_W-1:0]  data_in;
    logic [2:0]         tof_index;
    logic               m_valid;
    logic               m_ready;
    logic [ENTRY_W-1:0] m_data;
    logic [4:0]         fifo_level;
    logic               overflow;
    logic               clr_overflow;

    logic [DATA_W-1:0]  data_tab [NB];

    int errors = 0;
    int checks = 0;

    // Model state
    logic [ENTRY_W-1:0] q[$];
    int   cyc, cap_cyc, free_cyc, sel, rr;
    bit   cap_pend, ovf, hold_ready, cap_soon;
    logic [15:0] ts_m;

    always #5 clk = ~clk;

    // Comm block data mux follows the select.
    assign data_in = data_tab[tof_index];

    tof_result_collector #(
        .NB_OF_SENSORS (NB),
        .FIFO_DEPTH    (DEPTH),
        .SEL_W         (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ready_in     (ready_vec),
        .data_in      (data_in),
        .tof_index    (tof_index),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cyc = 0; cap_cyc = 0; free_cyc = 0; sel = 0; rr = 0;
        cap_pend = 0; ovf = 0; cap_soon = 0; ts_m = 16'd0;
    endtask

    // Advance the model over one clock edge using the inputs of that cycle.
    task automatic model_step();
        logic [NB-1:0]      rdy;
        logic [ENTRY_W-1:0] e;
        bit pop, cap, drop, found;
        rdy   = ready_vec;
        pop   = (q.size() != 0) && m_ready;
        cap   = cap_pend && (cyc == cap_cyc);
        drop  = 0;
        e     = '0;
        if (cap) begin
`ifdef TOF_COLLECT_TIMESTAMP_EN
            e = {ts_m, 3'(sel), data_tab[sel]};
`else
            e = {3'(sel), data_tab[sel]};
`endif
            drop = (q.size() == DEPTH) && !pop;
        end
        if (pop) void'(q.pop_front());
        if (cap && !drop) q.push_back(e);
        if (cap && drop) ovf = 1;
        else if (clr_overflow) ovf = 0;
        if (cap) begin
            rr = (sel + 1) % NB;
            cap_pend = 0;
            if (!hold_ready) ready_vec[sel] = 1'b0;
        end
        if (cyc >= free_cyc) begin
            found = 0;
            for (int k = 0; k < NB; k++) begin
                if (!found && rdy[(rr + k) % NB]) begin
                    found = 1;
                    sel = (rr + k) % NB;
                    cap_pend = 1;
                    cap_cyc = cyc + 2;
                    free_cyc = cyc + 3;
                end
            end
        end
        ts_m = ts_m + 16'd1;
        cyc++;
        cap_soon = cap_pend && (cap_cyc == cyc);
    endtask

    task automatic compare();
        chk("tof_index", tof_index, sel);
        chk("m_valid", m_valid, q.size() != 0);
        chk("fifo_level", fifo_level, q.size());
        chk("overflow", overflow, ovf);
        if (q.size() != 0) chk("m_data", m_data, q[0]);
    endtask

    // One clock: model + compare just after the edge, return at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) model_reset();
        else model_step();
        compare();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; ready_vec = '0; m_ready = 1'b0; clr_overflow = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [2:0]  ids [16];
        int          tim [16];
        int          n;
        bit          done;
        logic [15:0] t0, t1;

        reset = 1'b0; ready_vec = 8'hFF; m_ready = 1'b0; clr_overflow = 1'b0;
        hold_ready = 1;
        for (int s = 0; s < NB; s++) data_tab[s] = {6'(s + 1), 16'(1000 + 37 * s)};
        model_reset();

        // 1: reset held with all ready bits set, then first grant
        repeat (3) tick();
        chk("rst_tof_index", tof_index, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_m_data", m_data, 0);
        reset = 1'b1;
        tick();
        chk("first_grant", tof_index, 0);
        tick(); tick();
        chk("first_valid", m_valid, 1);
        chk("first_entry", m_data[24:0], {3'd0, 6'd1, 16'd1000});

        // 2: single sensor, latency and field packing (also resets mid-run)
        do_reset();
        hold_ready = 0;
        data_tab[5] = 22'h0A01F4;
        ready_vec = 8'b0010_0000;
        tick(); chk("t2_lat_c1", m_valid, 0);
        tick(); chk("t2_lat_c2", m_valid, 0);
        tick(); chk("t2_lat_c3", m_valid, 1);
        chk("t2_entry", m_data[24:0], {3'd5, 6'h0A, 16'h01F4});
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("t2_drained", fifo_level, 0);

        // 3: all ready, consumer always ready -> fair rotation, 3-cycle spacing
        do_reset();
        hold_ready = 1; ready_vec = 8'hFF; m_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 80 && n < 16; k++) begin
            tick();
            if (m_valid) begin
                ids[n] = m_data[24:22];
                tim[n] = k;
                n++;
            end
        end
        chk("t3_count", n, 16);
        for (int i = 0; i < n; i++) chk("t3_id", ids[i], i % 8);
        for (int i = 1; i < n; i++) chk("t3_gap", tim[i] - tim[i-1], 3);

        // 4: consumer stalled, 17 results -> full + overflow, then clear
        do_reset();
        hold_ready = 1; ready_vec = 8'hFF; m_ready = 1'b0;
        repeat (53) tick();
        chk("t4_level_full", fifo_level, 16);
        chk("t4_overflow", overflow, 1);
        chk("t4_head_id", m_data[24:22], 0);
        ready_vec = '0;
        repeat (3) tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("t4_cleared", overflow, 0);

        // 5: full FIFO, pop exactly when a capture lands -> level holds
        ready_vec = 8'hFF;
        for (int k = 0; k < 12; k++) begin
            m_ready = cap_soon;
            tick();
        end
        m_ready = 1'b0;
        chk("t5_level", fifo_level, 16);
        chk("t5_no_ovf", overflow, 0);
        // drop and clear in the same cycle: the set wins
        done = 0;
        for (int k = 0; k < 6 && !done; k++) begin
            clr_overflow = cap_soon;
            done = cap_soon;
            tick();
        end
        clr_overflow = 1'b0;
        chk("t5_set_wins", overflow, 1);
        ready_vec = '0;
        repeat (3) tick();
        m_ready = 1'b1;
        repeat (20) tick();
        chk("t5_drained", fifo_level, 0);

`ifdef TOF_COLLECT_TIMESTAMP_EN
        // 6: timestamps 10 cycles apart, then the 0xFFFF -> 0 wrap
        do_reset();
        hold_ready = 0; m_ready = 1'b0;
        ready_vec = 8'b0000_0100;
        repeat (10) tick();
        ready_vec = 8'b0000_1000;
        repeat (5) tick();
        chk("t6_level", fifo_level, 2);
        t0 = m_data[40:25];
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        t1 = m_data[40:25];
        chk("t6_ts_first", t0, 16'd2);
        chk("t6_ts_diff", t1 - t0, 10);
        m_ready = 1'b1;
        for (int k = 0; k < 70000 && ts_m != 16'hFFFD; k++) tick();
        chk("t6_reach_wrap", ts_m, 16'hFFFD);
        m_ready = 1'b0;
        ready_vec = 8'b0000_0001;
        repeat (3) tick();
        ready_vec = 8'b0000_0010;
        repeat (4) tick();
        chk("t6_ts_ffff", m_data[40:25], 16'hFFFF);
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        chk("t6_ts_wrapped", m_data[40:25], 16'h0002);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
